// File: rtl/if_prefetch_queue.sv
// if_prefetch_queue -- instruction prefetch queue between the fetch port and decode.
// Issues sequential fetches under a credit limit, buffers in-order returns with their
// pc+4 tag, and squashes everything on a redirect by counting stale returns to discard.
// Optional feature: define IFQ_BYPASS_EN to let a response reach decode combinationally
// when the queue is empty.
`timescale 1ns/1ps
module if_prefetch_queue #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic                       imem_req_valid,
  output logic [ADDR_W-1:0]          imem_req_addr,
  input  logic                       imem_req_ready,
  input  logic                       imem_rsp_valid,
  input  logic [DATA_W-1:0]          imem_rsp_data,
  output logic                       id_valid,
  output logic [DATA_W-1:0]          id_ins,
  output logic [ADDR_W-1:0]          id_pc_plus4,
  input  logic                       id_ready,
  input  logic                       redirect_valid,
  input  logic [ADDR_W-1:0]          redirect_addr,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  // Back-to-back redirects can leave several generations of stale returns outstanding.
  localparam int unsigned STALE_W = CNT_W + 2;

  logic [ADDR_W-1:0]  pc;
  logic               run;          // low for the first cycle after reset release
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W-1:0]   occ;
  logic [STALE_W-1:0] stale_cnt;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [DATA_W-1:0]  ins_mem [DEPTH];
  logic [ADDR_W-1:0]  pc4_mem [DEPTH];

  logic              req_fire;
  logic              stale_rsp;
  logic              good_rsp;
  logic              has_credit;
  logic              bypass_hit;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] rsp_pc_plus4;

  assign occupancy     = occ;
  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid && imem_req_ready;
  assign stale_rsp     = imem_rsp_valid && (stale_cnt != '0);
  // A return with nothing live outstanding (e.g. one issued before a reset) is ignored.
  assign good_rsp      = imem_rsp_valid && (stale_cnt == '0) && (inflight != '0);
  // Returns are in order, so the returning word belongs to the oldest live request,
  // which was issued 'inflight' words behind the current PC.
  assign rsp_pc_plus4  = pc - ADDR_W'({inflight, 2'b00}) + ADDR_W'(4);

  // Head view toward decode, optionally bypassing an empty queue.
  always_comb begin : head_view
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    bypass_hit  = 1'b0;
    id_valid    = (occ != '0);
    id_ins      = ins_mem[head];
    id_pc_plus4 = pc4_mem[head];
`ifdef IFQ_BYPASS_EN
    if ((occ == '0) && good_rsp && !redirect_valid) begin
      bypass_hit  = 1'b1;
      id_valid    = 1'b1;
      id_ins      = imem_rsp_data;
      id_pc_plus4 = rsp_pc_plus4;
    end
`endif
  end

  // Request credit and queue push/pop decisions; redirect overrides push and request.
  always_comb begin : flow_ctrl
    has_credit     = ({1'b0, occ} + {1'b0, inflight}) < (CNT_W + 1)'(DEPTH);
    imem_req_valid = run && !redirect_valid && has_credit;
    pop            = (occ != '0) && id_ready;
    push           = good_rsp && !redirect_valid && !(bypass_hit && id_ready);
  end

  // Fetch PC, inflight credit and stale-return bookkeeping.
  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      pc        <= RESET_PC;
      run       <= 1'b0;
      inflight  <= '0;
      stale_cnt <= '0;
    end else begin
      run <= 1'b1;
      if (redirect_valid) begin
        pc        <= redirect_addr;
        inflight  <= '0;
        // Everything still live at the memory becomes stale; a live return this cycle
        // has already come back, so it is not counted.
        stale_cnt <= stale_cnt - STALE_W'(stale_rsp) + STALE_W'(inflight)
                     + STALE_W'(req_fire) - STALE_W'(good_rsp);
      end else begin
        if (req_fire) pc <= pc + ADDR_W'(4);
        inflight <= inflight + CNT_W'(req_fire) - CNT_W'(good_rsp);
        if (stale_rsp) stale_cnt <= stale_cnt - STALE_W'(1);
      end
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else if (redirect_valid) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      occ <= occ + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Queue storage: instruction word plus its pc+4 tag.
  always_ff @(posedge clock) begin
    // NOTE: storage is not reset; occupancy alone decides which entries are meaningful.
    if (push) begin
      ins_mem[tail] <= imem_rsp_data;
      pc4_mem[tail] <= rsp_pc_plus4;
    end
  end

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 32, meaning fetch address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning queue entries; legal values are powers of two from 2 to 16.
REQ-004 The module SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-005 The module SHALL have port clock  in  1  single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 The module SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-008 The module SHALL have port imem_req_addr  out  ADDR_W  fetch address.
REQ-009 The module SHALL have port imem_req_ready  in  1  memory accepts the request.
REQ-010 The module SHALL have port imem_rsp_valid  in  1  instruction return valid; returns arrive in request order, latency >=1 cycle.
REQ-011 The module SHALL have port imem_rsp_data  in  DATA_W  returned instruction.
REQ-012 The module SHALL have port id_valid  out  1  queue head valid toward decode.
REQ-013 The module SHALL have port id_ins  out  DATA_W  head instruction.
REQ-014 The module SHALL have port id_pc_plus4  out  ADDR_W  head fetch address + 4.
REQ-015 The module SHALL have port id_ready  in  1  decode consumes head; low = stall.
REQ-016 The module SHALL have port redirect_valid  in  1  branch/jump/jr redirect.
REQ-017 The module SHALL have port redirect_addr  in  ADDR_W  redirect target.
REQ-018 The module SHALL have port occupancy  out  $clog2(DEPTH+1)  valid entries in the queue.

Function
REQ-019 The fetch PC register SHALL advance by 4 (modulo 2^ADDR_W) on every cycle with imem_req_valid && imem_req_ready.
REQ-020 imem_req_valid SHALL be high only when occupancy + inflight < DEPTH and redirect_valid is low; inflight counts accepted, unreturned, non-stale requests (0..DEPTH).
REQ-021 A response with stale_cnt == 0 SHALL be written to the tail, tagged with its fetch address + 4, and SHALL raise occupancy by 1 and lower inflight by 1.
REQ-022 A pop (id_valid && id_ready) SHALL advance the head pointer; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-023 Head and tail pointers SHALL wrap modulo DEPTH; full (occupancy == DEPTH) SHALL never overflow, because of the credit rule in REQ-020.
REQ-024 id_valid SHALL equal (occupancy != 0); id_ins and id_pc_plus4 SHALL hold steady while id_valid && !id_ready.
REQ-025 On redirect_valid, the next cycle SHALL have: PC = redirect_addr, occupancy = 0, pointers reset, stale_cnt = inflight (including any request accepted that cycle), inflight = 0.
REQ-026 Responses arriving while stale_cnt > 0 SHALL be discarded and SHALL decrement stale_cnt.
REQ-027 Redirect SHALL take priority over a same-cycle push, pop or request; a same-cycle pop is still consumed by decode.
REQ-028 Back-to-back redirects SHALL accumulate stale_cnt correctly; the last target wins.

Reset
REQ-029 While reset is low: PC = RESET_PC, imem_req_valid = 0, id_valid = 0, occupancy = 0, inflight = 0, stale_cnt = 0, pointers = 0.
REQ-030 Reset asserted mid-operation SHALL abandon all queued and inflight state immediately; the first request after release SHALL be to RESET_PC.

Configuration
REQ-031 Macro IFQ_BYPASS_EN defined: when the queue is empty, a non-stale response SHALL drive id_valid/id_ins/id_pc_plus4 combinationally in the same cycle, and SHALL not be enqueued if id_ready is high.
REQ-032 IFQ_BYPASS_EN undefined: every response SHALL pass through the queue, giving a minimum of 1 cycle from response to id_valid.

Verification
REQ-033 The bench SHALL cover: release reset, imem ready=1, latency 1 -> requests at 0x0, 0x4, 0x8; first id_pc_plus4 = 0x4; sustained 1 instruction/cycle.
REQ-034 The bench SHALL cover: DEPTH=4, id_ready=0 for 10 cycles -> occupancy reaches 4, imem_req_valid = 0, no data lost; release -> 4 pops in order.
REQ-035 The bench SHALL cover: 2 requests in flight, redirect to 0x100 -> both returns dropped, next id_valid word fetched from 0x100, id_pc_plus4 = 0x104.
REQ-036 The bench SHALL cover: redirect in the same cycle as a push and a pop -> occupancy = 0 next cycle, and the popped word was seen exactly once.
REQ-037 The bench SHALL cover: reset pulsed low with 3 queued entries and 1 in flight -> all outputs at reset values; after release the first request is to RESET_PC and the late response is discarded.
REQ-038 The bench SHALL cover: IFQ_BYPASS_EN defined, queue empty, id_ready=1, response arrives -> id_valid is high in the same cycle and occupancy stays 0.
